// File: rtl/direct_drain.sv
// -----------------------------------------------------------------------------
// direct_drain
//   AXI4-Stream sink for the direct stream interface. It always accepts traffic
//   (optionally throttled), discards the payload and keeps per-packet statistics
//   and sticky protocol-error flags.
//
// Ports
//   aclk        clock
//   aresetn     asynchronous active-low reset
//   dt_tvalid   stream valid
//   dt_tready   stream ready (registered)
//   dt_tdata    payload (ignored)
//   dt_tkeep    byte enables
//   dt_tlast    end of packet
//   dt_tuser    sideband, expected constant across a packet
//   clear       synchronous clear of counters, last_tuser and error flags
//   pkt_count   completed packets (saturating)
//   byte_count  accepted bytes, sum of popcount(tkeep) (saturating)
//   last_tuser  tuser of the most recently completed packet
//   in_packet   high between first and last beat of a packet
//   pkt_done    one-cycle pulse per completed packet
//   err_keep    sticky: illegal tkeep seen
//   err_user    sticky: tuser changed mid-packet
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module direct_drain #(
  parameter int DATA_WIDTH      = 512,
  parameter int KEEP_WIDTH      = 64,
  parameter int USER_WIDTH      = 64,
  parameter int CNT_WIDTH       = 32,
  parameter int THROTTLE_PERIOD = 0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  dt_tvalid,
  output logic                  dt_tready,
  input  logic [DATA_WIDTH-1:0] dt_tdata,
  input  logic [KEEP_WIDTH-1:0] dt_tkeep,
  input  logic                  dt_tlast,
  input  logic [USER_WIDTH-1:0] dt_tuser,
  input  logic                  clear,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  byte_count,
  output logic [USER_WIDTH-1:0] last_tuser,
  output logic                  in_packet,
  output logic                  pkt_done,
  output logic                  err_keep,
  output logic                  err_user
);

  // Width of a per-beat byte count (0..KEEP_WIDTH inclusive).
  localparam int POP_W = $clog2(KEEP_WIDTH) + 1;

  // Throttle counter sizing; a 1-bit dummy counter is kept when unthrottled.
  localparam int THR_W      = (THROTTLE_PERIOD > 1) ? $clog2(THROTTLE_PERIOD) : 1;
  localparam int THR_LAST_I = (THROTTLE_PERIOD > 1) ? (THROTTLE_PERIOD - 1) : 0;
  localparam logic [THR_W-1:0] THR_LAST = THR_LAST_I[THR_W-1:0];

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_IN_PKT = 1'b1
  } state_t;

  // Number of enabled bytes in a beat.
  function automatic logic [POP_W-1:0] f_popcount(input logic [KEEP_WIDTH-1:0] keep);
    logic [POP_W-1:0] cnt;
    cnt = {POP_W{1'b0}};
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      cnt = cnt + {{(POP_W-1){1'b0}}, keep[i]};
    end
    return cnt;
  endfunction

  // True when keep has the form 2^k-1 (all set bits packed at the LSB end).
  // Adding one to such a value clears every set bit, so the AND is zero.
  function automatic logic f_lsb_contig(input logic [KEEP_WIDTH-1:0] keep);
    logic [KEEP_WIDTH-1:0] plus1;
    plus1 = keep + {{(KEEP_WIDTH-1){1'b0}}, 1'b1};
    return ((keep & plus1) == {KEEP_WIDTH{1'b0}});
  endfunction

  // Illegal byte-enable pattern for this beat position.
  function automatic logic f_keep_bad(input logic [KEEP_WIDTH-1:0] keep, input logic last);
    logic bad;
    if (keep == {KEEP_WIDTH{1'b0}}) begin
      bad = 1'b1;
    end else if (!last) begin
      bad = (keep != {KEEP_WIDTH{1'b1}});
    end else begin
      bad = !f_lsb_contig(keep);
    end
    return bad;
  endfunction

  logic [THR_W-1:0]      r_thr_cnt;
  logic [THR_W-1:0]      w_thr_nxt;
  logic                  w_tready_nxt;
  logic                  r_tready;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_idle;
  logic                  w_capture;
  logic                  w_user_mismatch;

  logic                  w_beat;
  logic                  w_count;
  logic [POP_W-1:0]      w_pop;
  logic                  w_keep_bad;
  logic [CNT_WIDTH:0]    w_byte_sum;
  logic [CNT_WIDTH:0]    w_pkt_sum;

  logic [USER_WIDTH-1:0] r_cap_user;
  logic [CNT_WIDTH-1:0]  r_pkt_count;
  logic [CNT_WIDTH-1:0]  r_byte_count;
  logic [USER_WIDTH-1:0] r_last_tuser;
  logic                  r_pkt_done;
  logic                  r_err_keep;
  logic                  r_err_user;

  // Payload is intentionally discarded.
  logic                  w_unused_tdata;
  assign w_unused_tdata = ^dt_tdata;

  assign w_beat     = dt_tvalid & r_tready;
  // A beat coincident with clear still moves the FSM but is not accounted.
  assign w_count    = w_beat & ~clear;
  assign w_pop      = f_popcount(dt_tkeep);
  assign w_keep_bad = f_keep_bad(dt_tkeep, dt_tlast);
  assign w_byte_sum = {1'b0, r_byte_count} + {{(CNT_WIDTH+1-POP_W){1'b0}}, w_pop};
  assign w_pkt_sum  = {1'b0, r_pkt_count} + {{CNT_WIDTH{1'b0}}, 1'b1};

  // Next throttle count and next ready; ready drops in the slot where the
  // counter will sit at N-1.
  always_comb begin
    w_thr_nxt    = {THR_W{1'b0}};
    w_tready_nxt = 1'b1;
    if (THROTTLE_PERIOD > 1) begin
      if (r_thr_cnt == THR_LAST) begin
        w_thr_nxt = {THR_W{1'b0}};
      end else begin
        w_thr_nxt = r_thr_cnt + {{(THR_W-1){1'b0}}, 1'b1};
      end
      w_tready_nxt = (w_thr_nxt != THR_LAST);
    end else begin
      w_thr_nxt    = {THR_W{1'b0}};
      w_tready_nxt = 1'b1;
    end
  end

  // Throttle counter and registered ready.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_thr_cnt <= {THR_W{1'b0}};
      r_tready  <= 1'b0;
    end else begin
      r_thr_cnt <= w_thr_nxt;
      r_tready  <= w_tready_nxt;
    end
  end

  // FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_beat && !dt_tlast) begin
          w_state_nxt = S_IN_PKT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IN_PKT: begin
        if (w_beat && dt_tlast) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_IN_PKT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM output decode.
  always_comb begin
    w_idle          = 1'b1;
    w_capture       = 1'b0;
    w_user_mismatch = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idle    = 1'b1;
        w_capture = w_beat & ~dt_tlast;
      end
      S_IN_PKT: begin
        w_idle          = 1'b0;
        w_user_mismatch = w_beat & (dt_tuser != r_cap_user);
      end
      default: begin
        w_idle = 1'b1;
      end
    endcase
  end

  // Captured tuser of the open packet; follows beats even under clear so the
  // consistency check stays meaningful for the rest of the packet.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cap_user <= {USER_WIDTH{1'b0}};
    end else if (w_capture) begin
      r_cap_user <= dt_tuser;
    end else begin
      r_cap_user <= r_cap_user;
    end
  end

  // Completion pulse, independent of clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_pkt_done <= 1'b0;
    end else begin
      r_pkt_done <= w_beat & dt_tlast;
    end
  end

  // Saturating packet/byte counters and last completed tuser.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_pkt_count  <= {CNT_WIDTH{1'b0}};
      r_byte_count <= {CNT_WIDTH{1'b0}};
      r_last_tuser <= {USER_WIDTH{1'b0}};
    end else if (clear) begin
      r_pkt_count  <= {CNT_WIDTH{1'b0}};
      r_byte_count <= {CNT_WIDTH{1'b0}};
      r_last_tuser <= {USER_WIDTH{1'b0}};
    end else if (w_count) begin
      r_byte_count <= w_byte_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_byte_sum[CNT_WIDTH-1:0];
      if (dt_tlast) begin
        r_pkt_count  <= w_pkt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_pkt_sum[CNT_WIDTH-1:0];
        r_last_tuser <= dt_tuser;
      end else begin
        r_pkt_count  <= r_pkt_count;
        r_last_tuser <= r_last_tuser;
      end
    end else begin
      r_pkt_count  <= r_pkt_count;
      r_byte_count <= r_byte_count;
      r_last_tuser <= r_last_tuser;
    end
  end

  // Sticky protocol-error flags.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_err_keep <= 1'b0;
      r_err_user <= 1'b0;
    end else if (clear) begin
      r_err_keep <= 1'b0;
      r_err_user <= 1'b0;
    end else begin
      r_err_keep <= r_err_keep | (w_count & w_keep_bad);
      r_err_user <= r_err_user | (w_user_mismatch & ~clear);
    end
  end

  assign dt_tready  = r_tready;
  assign pkt_count  = r_pkt_count;
  assign byte_count = r_byte_count;
  assign last_tuser = r_last_tuser;
  assign in_packet  = ~w_idle;
  assign pkt_done   = r_pkt_done;
  assign err_keep   = r_err_keep;
  assign err_user   = r_err_user;

endmodule
